// File: rtl/modred_word_pipe_pkg.sv
// Shared constants and helpers for the word-level Montgomery reducer.
// Default widths and the step-count helper used by the pipeline top.
package modred_word_pipe_pkg;

  localparam int DEF_DATA_SIZE = 14;
  localparam int DEF_W_SIZE    = 12;

  // Ceiling division: number of W-bit words needed to cover a width.
  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Internal datapath width of every reduction step.
  function automatic int step_width(input int data_size);
    return 2 * data_size + 1;
  endfunction

endpackage

// File: rtl/modred_word_step.sv
// One Montgomery word-reduction step: y = (x + q*T2) / 2^W_SIZE.
// Ports: clk, reset (sync, active-low), adv (stage enable), qh (q>>W),
//   in_valid/x (operand), out_valid/y (reduced value, two cycles later).
module modred_word_step
  import modred_word_pipe_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int W_SIZE    = DEF_W_SIZE,
  parameter int IN_W      = 2 * DEF_DATA_SIZE + 1,
  parameter int OUT_W     = 2 * DEF_DATA_SIZE + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        adv,
  input  logic [DATA_SIZE-W_SIZE-1:0] qh,
  input  logic                        in_valid,
  input  logic [IN_W-1:0]             x,
  output logic                        out_valid,
  output logic [OUT_W-1:0]            y
);

  localparam int QH_W = DATA_SIZE - W_SIZE;
  localparam int HI_W = IN_W - W_SIZE;
  localparam int P_W  = QH_W + W_SIZE;

  logic [W_SIZE-1:0] lo;
  logic [W_SIZE-1:0] t2;
  logic [P_W-1:0]    prod;

  assign lo   = x[W_SIZE-1:0];
  // T2 = -lo mod 2^W makes the low word of x + q*T2 vanish.
  assign t2   = -lo;
  assign prod = P_W'(qh) * P_W'(t2);

  logic              a_valid;
  logic [HI_W-1:0]   a_hi;
  (* use_dsp = "yes" *)
  logic [P_W-1:0]    a_prod;
  logic              a_carry;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_valid   <= 1'b0;
      a_hi      <= '0;
      a_prod    <= '0;
      a_carry   <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
    end else if (adv) begin
      a_valid   <= in_valid;
      a_hi      <= x[IN_W-1:W_SIZE];
      a_prod    <= prod;
      // lo + T2 equals 2^W exactly when lo is non-zero.
      a_carry   <= |lo;
      out_valid <= a_valid;
      y         <= OUT_W'(a_hi) + OUT_W'(a_prod) + OUT_W'(a_carry);
    end
  end

endmodule

// File: rtl/modred_word_pipe.sv
// Pipelined word-level Montgomery reducer: C = T*2^(-W*L) mod q in [0,q).
// Ports: clk, reset (sync, active-low), q, in_valid/in_ready/T,
//   out_valid/out_ready/C, q_err (registered: q mod 2^W != 1).
module modred_word_pipe
  import modred_word_pipe_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int W_SIZE    = DEF_W_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_SIZE-1:0]   q,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*DATA_SIZE-1:0] T,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_SIZE-1:0]   C,
  output logic                   q_err
);

  localparam int L  = cdiv(DATA_SIZE, W_SIZE);
  localparam int XW = step_width(DATA_SIZE);

  // Whole pipeline advances together; a held output freezes everything.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic [DATA_SIZE-W_SIZE-1:0] qh;
  assign qh = q[DATA_SIZE-1:W_SIZE];

  logic [L:0][XW-1:0] sx;
  logic [L:0]         sv;

  assign sx[0] = XW'(T);
  assign sv[0] = in_valid;

  for (genvar i = 0; i < L; i++) begin : g_step
    modred_word_step #(
      .DATA_SIZE (DATA_SIZE),
      .W_SIZE    (W_SIZE),
      .IN_W      (XW),
      .OUT_W     (XW)
    ) u_step (
      .clk       (clk),
      .reset     (reset),
      .adv       (adv),
      .qh        (qh),
      .in_valid  (sv[i]),
      .x         (sx[i]),
      .out_valid (sv[i+1]),
      .y         (sx[i+1])
    );
  end

  // Step output is below 2q, so one conditional subtraction is canonical.
  logic [XW-1:0]        r;
  logic [XW-1:0]        q_ext;
  logic [DATA_SIZE-1:0] c_next;

  assign r      = sx[L];
  assign q_ext  = XW'(q);
  assign c_next = (r >= q_ext) ? DATA_SIZE'(r - q_ext)
                               : DATA_SIZE'(r);

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      C         <= '0;
      q_err     <= 1'b0;
    end else begin
      q_err <= (q[W_SIZE-1:0] != W_SIZE'(1));
      if (adv) begin
        out_valid <= sv[L];
        C         <= c_next;
      end
    end
  end

endmodule
